// File: rtl/mod_counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package mod_counter_pkg;

    // SATURATE parameter encodings
    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // up_dn input encodings
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Gray code of the low 'width' bits of bin. Callers zero-extend their
    // value into 32 bits and cast the result back to their own width.
    function automatic logic [31:0] bin2gray(input logic [31:0] bin,
                                             input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? '1 : ((32'd1 << width) - 32'd1);
        return (bin ^ (bin >> 1)) & mask;
    endfunction

endpackage

// File: rtl/clk_prescaler.sv
// Enable divider: emits one step per PRESCALE enabled clocks.
// restart forces the phase back to zero so a new period begins.
module clk_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic restart,
    output logic step
);

    generate
        if (PRESCALE <= 1) begin : g_bypass
            // No divider needed: every enabled clock is a step.
            logic unused_bypass;
            assign unused_bypass = ^{clk, rst_n, restart};
            assign step = en;
        end else begin : g_div
            localparam int PW = $clog2(PRESCALE);
            localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

            logic [PW-1:0] presc_q, presc_d;

            // Phase advances only while enabled; restart wins over en.
            always_comb begin
                presc_d = presc_q;
                if (restart)
                    presc_d = '0;
                else if (en)
                    presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
            end

            // Phase register.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) presc_q <= '0;
                else        presc_q <= presc_d;
            end

            assign step = en && (presc_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mod_updown_counter.sv
// Synchronous modulus up/down counter with load, clear, prescaled enable,
// wrap/saturate mode, registered Gray output and tc/wrap flags.
module mod_updown_counter
    import mod_counter_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 15,
    parameter int PRESCALE = 1,
    parameter int SATURATE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] q_gray,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);

    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] gray_q, gray_d;
    logic             wrap_q, wrap_d;
    logic             step;
    logic             restart;

    // clr and load both begin a fresh prescaler period.
    assign restart = clr | load;

    clk_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_presc (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .restart (restart),
        .step    (step)
    );

    // Next count: clr > load > step. Limits are compared before any
    // add/subtract so the value never leaves 0..MAX_VAL, even when
    // MAX_VAL fills the whole word.
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = (load_val > MAXV) ? MAXV : load_val;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (count_q >= MAXV) begin
                    if (SATURATE == MODE_SAT) begin
                        count_d = MAXV;
                    end else begin
                        count_d = '0;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (count_q == '0) begin
                    if (SATURATE == MODE_SAT) begin
                        count_d = '0;
                    end else begin
                        count_d = MAXV;
                        wrap_d  = 1'b1;
                    end
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
    end

    // Gray code is taken from the next value so it lands with q.
    assign gray_d = WIDTH'(bin2gray(32'(count_d), WIDTH));

    // Count, Gray and wrap-pulse registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
            gray_q  <= '0;
            wrap_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            gray_q  <= gray_d;
            wrap_q  <= wrap_d;
        end
    end

    assign q      = count_q;
    assign q_gray = gray_q;
    assign wrap   = wrap_q;

    // Terminal count feeds the next cascaded stage's enable, so it is
    // combinational and independent of the prescaler phase.
    assign tc = en && (((up_dn == DIR_UP)   && (count_q == MAXV)) ||
                       ((up_dn == DIR_DOWN) && (count_q == '0)));

endmodule

// File: tb/tb_mod_updown_counter.sv
// Randomised bench: several counter configurations plus a two-stage decade
// cascade, all compared against an arithmetic reference model.
module tb_mod_updown_counter;

    localparam int NCFG = 4;
    localparam int MAXA [NCFG] = '{9, 9, 9, 15};
    localparam int PSCA [NCFG] = '{1, 1, 3, 1};
    localparam int SATA [NCFG] = '{0, 1, 0, 0};

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up_dn, clr, load;
    logic [3:0] load_val;
    logic       c_en, c_clr;

    logic [3:0] q_w [NCFG];
    logic [3:0] g_w [NCFG];
    logic       tc_w [NCFG];
    logic       wr_w [NCFG];

    logic [3:0] q_u, q_t, g_u, g_t;
    logic       tc_u, tc_t, wr_u, wr_t;

    int n_chk = 0;
    int n_err = 0;

    // reference model state
    int mq [NCFG];
    int mp [NCFG];
    int mw [NCFG];
    int cval, mwu, mwt;

    always #5 clk = ~clk;

    generate
        for (genvar g = 0; g < NCFG; g++) begin : g_dut
            mod_updown_counter #(
                .WIDTH(4), .MAX_VAL(MAXA[g]), .PRESCALE(PSCA[g]), .SATURATE(SATA[g])
            ) u_dut (
                .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .clr(clr),
                .load(load), .load_val(load_val), .q(q_w[g]), .q_gray(g_w[g]),
                .tc(tc_w[g]), .wrap(wr_w[g])
            );
        end
    endgenerate

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_units (
        .clk(clk), .rst_n(rst_n), .en(c_en), .up_dn(1'b1), .clr(c_clr),
        .load(1'b0), .load_val(4'd0), .q(q_u), .q_gray(g_u), .tc(tc_u), .wrap(wr_u)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .PRESCALE(1), .SATURATE(0)) u_tens (
        .clk(clk), .rst_n(rst_n), .en(tc_u), .up_dn(1'b1), .clr(c_clr),
        .load(1'b0), .load_val(4'd0), .q(q_t), .q_gray(g_t), .tc(tc_t), .wrap(wr_t)
    );

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int gray(input int v);
        return v ^ (v >> 1);
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NCFG; i++) begin
            mq[i] = 0; mp[i] = 0; mw[i] = 0;
        end
        cval = 0; mwu = 0; mwt = 0;
    endfunction

    // One rising edge of the specification's behaviour.
    function automatic void model_edge();
        for (int i = 0; i < NCFG; i++) begin
            mw[i] = 0;
            if (clr) begin
                mq[i] = 0; mp[i] = 0;
            end else if (load) begin
                mq[i] = (int'(load_val) > MAXA[i]) ? MAXA[i] : int'(load_val);
                mp[i] = 0;
            end else if (en) begin
                mp[i] = mp[i] + 1;
                if (mp[i] == PSCA[i]) begin
                    mp[i] = 0;
                    if (up_dn) begin
                        if (mq[i] < MAXA[i]) mq[i] = mq[i] + 1;
                        else if (SATA[i] == 0) begin mq[i] = 0; mw[i] = 1; end
                    end else begin
                        if (mq[i] > 0) mq[i] = mq[i] - 1;
                        else if (SATA[i] == 0) begin mq[i] = MAXA[i]; mw[i] = 1; end
                    end
                end
            end
        end
        mwu = 0; mwt = 0;
        if (c_clr) cval = 0;
        else if (c_en) begin
            if (cval % 10 == 9) mwu = 1;
            if (cval == 99)     mwt = 1;
            cval = (cval + 1) % 100;
        end
    endfunction

    task automatic check_regs();
        for (int i = 0; i < NCFG; i++) begin
            chk($sformatf("q[%0d]", i),    int'(q_w[i]),  mq[i]);
            chk($sformatf("gray[%0d]", i), int'(g_w[i]),  gray(mq[i]));
            chk($sformatf("wrap[%0d]", i), int'(wr_w[i]), mw[i]);
        end
        chk("casc_units", int'(q_u), cval % 10);
        chk("casc_tens",  int'(q_t), cval / 10);
        chk("casc_gray_u", int'(g_u), gray(cval % 10));
        chk("casc_gray_t", int'(g_t), gray(cval / 10));
        chk("casc_wrap_u", int'(wr_u), mwu);
        chk("casc_wrap_t", int'(wr_t), mwt);
    endtask

    task automatic check_tc();
        int e;
        for (int i = 0; i < NCFG; i++) begin
            e = (en && (up_dn ? (mq[i] == MAXA[i]) : (mq[i] == 0))) ? 1 : 0;
            chk($sformatf("tc[%0d]", i), int'(tc_w[i]), e);
        end
        e = (c_en && (cval % 10 == 9)) ? 1 : 0;
        chk("casc_tc_u", int'(tc_u), e);
        e = (c_en && (cval == 99)) ? 1 : 0;
        chk("casc_tc_t", int'(tc_t), e);
    endtask

    // Apply inputs at the negedge, check tc, then one edge and register checks.
    task automatic drive(input logic e, input logic u, input logic c,
                         input logic l, input logic [3:0] lv);
        en = e; up_dn = u; clr = c; load = l; load_val = lv;
        c_en = ($urandom_range(0, 3) != 0); c_clr = 1'b0;
        #1;
        check_tc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_regs();
    endtask

    task automatic random_run(input int cycles);
        logic u;
        u = 1'b1;
        for (int k = 0; k < cycles; k++) begin
            if ($urandom_range(0, 7) == 0) u = ~u;
            drive(($urandom_range(0, 3) != 0), u,
                  ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
                  4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0;
        load_val = '0; c_en = 1'b0; c_clr = 1'b0;
        model_reset();
        #12;
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;

        // decade count up through a wrap
        for (int k = 0; k < 12; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);

        // down from 0: wrap vs saturate
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("down_wrap_q", int'(q_w[0]), 9);
        chk("down_wrap_pulse", int'(wr_w[0]), 1);
        chk("down_sat_q", int'(q_w[1]), 0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
        chk("down_sat_nowrap", int'(wr_w[1]), 0);

        // load clamp, clr over load, plain load
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd13);
        chk("load_clamp", int'(q_w[0]), 9);
        chk("load_full_range", int'(q_w[3]), 13);
        drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd5);
        chk("clr_over_load", int'(q_w[0]), 0);
        drive(1'b1, 1'b1, 1'b0, 1'b1, 4'd4);
        chk("load4_q", int'(q_w[0]), 4);
        chk("load4_gray", int'(g_w[0]), 6);

        // full-range 15 -> 0 wrap
        drive(1'b0, 1'b1, 1'b0, 1'b1, 4'd15);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("full_wrap_q", int'(q_w[3]), 0);
        chk("full_wrap_pulse", int'(wr_w[3]), 1);

        random_run(600);

        // async reset between edges after counting up
        drive(1'b0, 1'b1, 1'b1, 1'b0, 4'd0);
        for (int k = 0; k < 7; k++) drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("pre_reset_q", int'(q_w[0]), 7);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 1'b1, 1'b0, 1'b0, 4'd0);
        chk("post_reset_q", int'(q_w[0]), 1);

        // long cascade run to pass 99 -> 00 several times
        random_run(900);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
